switch_cmd_gen: RTL

//  Front-end command stage for the ON/OFF switch FSM. Conditions two raw push-buttons
//  (on, off) into clean single-cycle j/k command pulses, and adds an auto-off timeout.

---
 rtl/sw_ctrl_pkg.sv | 27 ++
 rtl/switch_cmd_gen_btn_debounce.sv | 107 ++++++++++
 rtl/switch_cmd_gen_chk.sv | 13 +
 rtl/switch_cmd_gen.sv | 85 ++++++++
 4 files changed

// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the switch command front-end: debounce state
// encodings, default timing parameters and a counter-width helper.
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    DB_LO     = 2'b00,
    DB_CHK_HI = 2'b01,
    DB_HI     = 2'b10,
    DB_CHK_LO = 2'b11
  } db_state_e;

  localparam logic [15:0] DB_CYCLES_DEF      = 16'd4;
  localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd1000;

  // Bits needed to count 0..v-1, never less than one bit.
  function automatic int cnt_width(input int unsigned v);
    int w;
    w = $clog2(v);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/switch_cmd_gen_btn_debounce.sv
// One push-button channel: two-flop synchronizer, four-state debounce FSM
// and a press strobe that fires on the edge where the level becomes high.
module btn_debounce
  import sw_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW       = cnt_width(32'(DB_CYCLES));
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 16'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam bit            SINGLE   = (DB_CYCLES == 16'd1);

  logic          meta_r;
  logic          sync_r;
  db_state_e     state_r;
  db_state_e     state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          press_s;

  // Next-state logic; the first differing sample already counts as one.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    press_s     = 1'b0;
    case (state_r)
      DB_LO: begin
        if (sync_r) begin
          if (SINGLE) begin
            state_nxt_s = DB_HI;
            cnt_nxt_s   = '0;
            press_s     = 1'b1;
          end else begin
            state_nxt_s = DB_CHK_HI;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      DB_CHK_HI: begin
        if (!sync_r) begin
          state_nxt_s = DB_LO;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = DB_HI;
          cnt_nxt_s   = '0;
          press_s     = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DB_HI: begin
        if (!sync_r) begin
          if (SINGLE) begin
            state_nxt_s = DB_LO;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = DB_CHK_LO;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      DB_CHK_LO: begin
        if (sync_r) begin
          state_nxt_s = DB_HI;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = DB_LO;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = DB_LO;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      state_r <= DB_LO;
      cnt_r   <= '0;
    end else begin
      meta_r  <= btn;
      sync_r  <= meta_r;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign press = press_s;

endmodule

// File: rtl/switch_cmd_gen_chk.sv
// Output-protocol checks for the command generator; simulation only.
module switch_cmd_gen_chk (
  input logic clk,
  input logic rst,
  input logic j,
  input logic k,
  input logic timeout
);

  a_jk_excl: assert property (@(posedge clk) disable iff (rst) !(j && k));
  a_to_with_k: assert property (@(posedge clk) disable iff (rst) timeout |-> k);

endmodule

// File: rtl/switch_cmd_gen.sv
// Command front-end for the ON/OFF switch FSM: debounced buttons become
// j/k pulses, with an auto-off timeout while the FSM reports ON.
module switch_cmd_gen
  import sw_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES      = DB_CYCLES_DEF,
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_on,
  input  logic btn_off,
  input  logic state_fb,
  output logic j,
  output logic k,
  output logic timeout
);

  localparam int            IW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1'b1);
  localparam bit            TO_EN     = (TIMEOUT_CYCLES != 32'd0);

  logic          on_press_s;
  logic          off_press_s;
  logic          hit_s;
  logic          j_nxt_s;
  logic          k_nxt_s;
  logic          to_nxt_s;
  logic [IW-1:0] idle_r;
  logic [IW-1:0] idle_nxt_s;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_on (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_on),
    .press (on_press_s)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_off (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_off),
    .press (off_press_s)
  );

  // Off beats on; any user press beats the timeout and restarts idle time.
  always_comb begin
    hit_s    = TO_EN && state_fb && (idle_r == IDLE_LAST);
    j_nxt_s  = on_press_s && !off_press_s;
    k_nxt_s  = off_press_s || (hit_s && !on_press_s);
    to_nxt_s = hit_s && !on_press_s && !off_press_s;
    if (!state_fb || on_press_s || off_press_s || hit_s) begin
      idle_nxt_s = '0;
    end else if (idle_r != '1) begin
      idle_nxt_s = idle_r + IDLE_ONE;
    end else begin
      idle_nxt_s = idle_r;
    end
  end

  // Output pulse and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      j       <= 1'b0;
      k       <= 1'b0;
      timeout <= 1'b0;
      idle_r  <= '0;
    end else begin
      j       <= j_nxt_s;
      k       <= k_nxt_s;
      timeout <= to_nxt_s;
      idle_r  <= idle_nxt_s;
    end
  end

  switch_cmd_gen_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .j       (j),
    .k       (k),
    .timeout (timeout)
  );

endmodule
